// File: rtl/ten_g_tx_frame_arbiter_pkg.sv
// Shared types and constants for the 10G TX frame arbiter and its reusable selector.
package ten_g_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;

endpackage

// File: rtl/ten_g_tx_frame_arbiter_if.sv
// Requester-side and MAC-side AXI-Stream bundle seen by the TX frame arbiter.
interface ten_g_tx_frame_arbiter_if
    import ten_g_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = AXIS_DATA_W,
    parameter int KEEP_W    = AXIS_KEEP_W
);
    logic [NUM_PORTS*DATA_W-1:0] s_tdata;
    logic [NUM_PORTS*KEEP_W-1:0] s_tkeep;
    logic [NUM_PORTS-1:0]        s_tvalid;
    logic [NUM_PORTS-1:0]        s_tlast;
    logic [NUM_PORTS-1:0]        s_tready;
    logic [DATA_W-1:0]           m_tdata;
    logic [KEEP_W-1:0]           m_tkeep;
    logic                        m_tvalid;
    logic                        m_tlast;
    logic                        m_tready;

    // master: the arbiter itself; slave: queues plus MAC around it
    modport master (
        input  s_tdata, s_tkeep, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
    );

    modport slave (
        output s_tdata, s_tkeep, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
    );
endinterface

// File: rtl/ten_g_tx_frame_arbiter_rr_arbiter.sv
// Combinational rotating-priority selector: first requester above last_grant wins,
// wrapping modulo N, so last_grant itself has the lowest priority.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);
    int cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        // Scan farthest offset first so the nearest request overwrites it.
        for (int k = N; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % N;
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/ten_g_tx_frame_arbiter.sv
// Frame-locked round-robin arbiter feeding one MAC TX AXI-Stream from several queues,
// with per-port completed-frame counters.
module ten_g_tx_frame_arbiter
    import ten_g_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int DATA_W    = AXIS_DATA_W,
    parameter  int KEEP_W    = AXIS_KEEP_W,
    parameter  int CNT_W     = 16,
    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                       user_clk,
    input  logic                       tx_axis_aresetn,
    ten_g_tx_frame_arbiter_if.master   axis,
    input  logic                       tx_fifo_full,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       busy,
    output logic [NUM_PORTS*CNT_W-1:0] frame_cnt
);
    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_XFER = 1'(XFER);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             in_xfer;
    logic             frame_done;

    rr_arbiter #(.N(NUM_PORTS)) u_rr (
        .req        (axis.s_tvalid),
        .last_grant (last_grant_q),
        .gnt_valid  (sel_valid),
        .gnt_idx    (sel_idx)
    );

    assign in_xfer    = (state_q == ST_XFER);
    assign frame_done = in_xfer && axis.m_tvalid && axis.m_tready && axis.m_tlast;
    assign grant_id   = grant_q;
    assign busy       = in_xfer;

    // Zero-latency pass-through of the granted port; everything idles at 0 otherwise.
    always_comb begin
        axis.m_tdata  = '0;
        axis.m_tkeep  = '0;
        axis.m_tvalid = 1'b0;
        axis.m_tlast  = 1'b0;
        if (in_xfer) begin
            axis.m_tdata  = axis.s_tdata[grant_q*DATA_W +: DATA_W];
            axis.m_tkeep  = axis.s_tkeep[grant_q*KEEP_W +: KEEP_W];
            axis.m_tvalid = axis.s_tvalid[grant_q];
            axis.m_tlast  = axis.s_tlast[grant_q];
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                // A full MAC FIFO only blocks new frames, never one already underway.
                if (sel_valid && !tx_fifo_full) begin
                    grant_d = sel_idx;
                    state_d = ST_XFER;
                end
            end
            default: begin
                if (frame_done) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge user_clk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [CNT_W-1:0] cnt_q;

            assign axis.s_tready[gi] = in_xfer && (grant_q == IDX_W'(gi)) && axis.m_tready;

            always_ff @(posedge user_clk or negedge tx_axis_aresetn) begin
                if (!tx_axis_aresetn) begin
                    cnt_q <= '0;
                end else if (frame_done && (grant_q == IDX_W'(gi))) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            assign frame_cnt[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate
endmodule
